// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Shared types for the sequential ALU: opcode encoding, controller state
//   encoding, result flag bundle and the iterative-unit mode select.
//
//   Optional feature macro: ALU_SEQ_DIV_EN
//     defined   -> DIVU/REMU are executed by the iterative unit
//     undefined -> DIVU/REMU are illegal opcodes (single cycle, err=1)
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_OR   = 4'b0000,
    OP_AND  = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_ADD  = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_NAND = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_DIVU = 4'b1100,
    OP_REMU = 4'b1101,
    OP_ANDN = 4'b1110,
    OP_XNOR = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
    logic err;
  } flags_t;

  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_mode_e;

  // Opcodes that take the multi-cycle path through alu_iter.
  function automatic logic is_iter_op(op_e op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// alu_iter
//   Bit-serial multiply (shift-add) and, when ALU_SEQ_DIV_EN is defined,
//   restoring unsigned divide. One bit per clock, WIDTH steps per operation.
//   The accumulator, shift register and operand register are shared by both
//   algorithms.
//
//   Ports
//     clk, rst_n  clock, asynchronous active-low reset
//     start       load operands and begin (one-cycle pulse)
//     a, b        operands (MUL: a*b, DIV: a/b)
//     done        step counter has reached terminal count (unit idle)
//     acc         MUL: product low WIDTH bits; DIV: remainder
//     mode        (ALU_SEQ_DIV_EN only) ITER_MUL / ITER_DIV, sampled at start
//     quo         (ALU_SEQ_DIV_EN only) DIV quotient
// ---------------------------------------------------------------------------
module alu_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_SEQ_DIV_EN
  input  iter_mode_e       mode,
  output logic [WIDTH-1:0] quo,
`endif
  output logic             done,
  output logic [WIDTH-1:0] acc
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] oper_q;

`ifdef ALU_SEQ_DIV_EN
  iter_mode_e       mode_q;
  logic [WIDTH:0]   rem_t;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and try to subtract the divisor. A zero divisor always "fits", which
  // naturally yields an all-ones quotient and a remainder equal to a.
  always_comb begin
    rem_t    = {acc_q, sreg_q[WIDTH-1]};
    rem_diff = rem_t - {1'b0, oper_q};
    rem_ge   = ~rem_diff[WIDTH];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sreg_q <= '0;
      oper_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode_q <= ITER_MUL;
`endif
    end else if (start) begin
      cnt_q <= CW'(WIDTH);
      acc_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode_q <= mode;
      if (mode == ITER_DIV) begin
        sreg_q <= a;
        oper_q <= b;
      end else begin
        sreg_q <= b;
        oper_q <= a;
      end
`else
      sreg_q <= b;
      oper_q <= a;
`endif
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
`ifdef ALU_SEQ_DIV_EN
      if (mode_q == ITER_DIV) begin
        acc_q  <= rem_ge ? rem_diff[WIDTH-1:0] : rem_t[WIDTH-1:0];
        sreg_q <= {sreg_q[WIDTH-2:0], rem_ge};
      end else begin
        if (sreg_q[0]) acc_q <= acc_q + oper_q;
        oper_q <= oper_q << 1;
        sreg_q <= sreg_q >> 1;
      end
`else
      if (sreg_q[0]) acc_q <= acc_q + oper_q;
      oper_q <= oper_q << 1;
      sreg_q <= sreg_q >> 1;
`endif
    end
  end

  assign done = (cnt_q == '0);
  assign acc  = acc_q;
`ifdef ALU_SEQ_DIV_EN
  assign quo  = sreg_q;
`endif

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Sequential ALU with valid/ready handshake on both sides. Logic, shift,
//   add/sub and compare ops finish one cycle after acceptance; MUL (and
//   DIVU/REMU when ALU_SEQ_DIV_EN is defined) run bit-serially in alu_iter
//   and finish WIDTH+1 cycles after acceptance. The result and flags are
//   held until the consumer takes them.
//
//   Optional feature macro: ALU_SEQ_DIV_EN (enables DIVU/REMU)
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     in_valid/in_ready  operation handshake (in_ready high only in IDLE)
//     a, b, csig         operands and opcode, captured on acceptance
//     out_valid/out_ready result handshake
//     out                registered result
//     z, n, v, c, err    registered flags
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a new operation
//   EXEC    | single-cycle op evaluating on captured operands
//   BUSY    | alu_iter stepping one bit per cycle
//   DONE    | result/flags presented, waiting for out_ready
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       csig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             c,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic [WIDTH-1:0] out_q;
  flags_t           flags_q;

  logic             accept;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_acc;
  logic [WIDTH-1:0] iter_res;
  logic             load_result;

  logic [WIDTH-1:0] res;
  flags_t           fl;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [SHW-1:0]   shamt;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign accept      = in_valid && in_ready;
  assign iter_start  = accept && is_iter_op(op_e'(csig));
  assign load_result = (state_q == ST_EXEC) || ((state_q == ST_BUSY) && iter_done);

  // ---- controller ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = is_iter_op(op_e'(csig)) ? ST_BUSY : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_BUSY: if (iter_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_OR;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_e'(csig);
    end
  end

  // ---- iterative unit: fed straight from the ports so it starts stepping
  //      on the cycle after acceptance ----
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] iter_quo;

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start),
    .a     (a),
    .b     (b),
    .mode  ((op_e'(csig) == OP_MUL) ? ITER_MUL : ITER_DIV),
    .quo   (iter_quo),
    .done  (iter_done),
    .acc   (iter_acc)
  );

  assign iter_res = (op_q == OP_DIVU) ? iter_quo : iter_acc;
`else
  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .acc   (iter_acc)
  );

  assign iter_res = iter_acc;
`endif

  // ---- result and flags ----
  always_comb begin
    res    = '0;
    fl     = '0;
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    diff_w = a_q - b_q;
    shamt  = b_q[SHW-1:0];

    if (state_q == ST_BUSY) begin
      res = iter_res;
    end else begin
      unique case (op_q)
        OP_OR:   res = a_q | b_q;
        OP_AND:  res = a_q & b_q;
        OP_XOR:  res = a_q ^ b_q;
        OP_SLL:  res = a_q << shamt;
        OP_SRL:  res = a_q >> shamt;
        OP_SUB: begin
          res  = diff_w;
          fl.c = (a_q >= b_q);
          fl.v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_ADD: begin
          res  = sum_w[WIDTH-1:0];
          fl.c = sum_w[WIDTH];
          fl.v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_NOR:  res = ~(a_q | b_q);
        OP_NAND: res = ~(a_q & b_q);
        OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
        OP_MUL:  res = '0;
        OP_SRA:  res = $unsigned($signed(a_q) >>> shamt);
`ifdef ALU_SEQ_DIV_EN
        OP_DIVU: res = '0;
        OP_REMU: res = '0;
`else
        // Divider not built: flag the opcode and return zero.
        OP_DIVU: fl.err = 1'b1;
        OP_REMU: fl.err = 1'b1;
`endif
        OP_ANDN: res = a_q & ~b_q;
        OP_XNOR: res = ~(a_q ^ b_q);
        default: res = '0;
      endcase
    end

    fl.z = (res == '0);
    fl.n = res[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else if (load_result) begin
      out_q   <= res;
      flags_q <= fl;
    end
  end

  assign out = out_q;
  assign z   = flags_q.z;
  assign n   = flags_q.n;
  assign v   = flags_q.v;
  assign c   = flags_q.c;
  assign err = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   csig = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         z, n, v, c, err;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .csig      (csig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .z         (z),
    .n         (n),
    .v         (v),
    .c         (c),
    .err       (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic [4:0]   fl;   // {z,n,v,c,err}
    int           lat;
    int           acc;
  } exp_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic [4:0]   fl;
    int           lat;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add_vec(input string name, input logic [3:0] op,
                                  input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input logic [W-1:0] vo, input logic [4:0] vf, input int lat);
    vec_t t;
    t.name = name; t.op = op; t.a = va; t.b = vb; t.out = vo; t.fl = vf; t.lat = lat;
    vecs.push_back(t);
  endfunction

  // Present one operation, wait for acceptance, optionally log the expected result.
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [W-1:0] eo, input logic [4:0] ef,
                       input int lat, input bit push);
    int   k;
    exp_t e;
    k = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; csig = op; a = ia; b = ib;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.name = name; e.out = eo; e.fl = ef; e.lat = lat; e.acc = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    check({name, "_in_ready_low"}, in_ready, 0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", sbq.size(), 0);
  endtask

  // ---- monitor / scoreboard ----
  bit           prev_v = 1'b0;
  bit           tracking = 1'b0;
  logic [W-1:0] snap_o;
  logic [4:0]   snap_f;
  exp_t         pe;

  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: out=%h appeared with nothing pending", out);
        tracking = 1'b0;
      end else begin
        check({sbq[0].name, "_latency"}, cyc - sbq[0].acc, sbq[0].lat);
        snap_o   = out;
        snap_f   = {z, n, v, c, err};
        tracking = 1'b1;
      end
    end else if (out_valid && prev_v && tracking) begin
      check("hold_stable", {out, z, n, v, c, err}, {snap_o, snap_f});
    end
    if (out_valid && out_ready && sbq.size() != 0) begin
      pe = sbq.pop_front();
      check({pe.name, "_out"}, out, pe.out);
      check({pe.name, "_flags"}, {z, n, v, c, err}, pe.fl);
    end
    prev_v = out_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int vcount;
    int k;

    // reset state
    @(negedge clk);
    check("rst_out", out, 0);
    check("rst_flags", {z, n, v, c, err}, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    //        name          op     a             b             out           {z,n,v,c,e} lat
    add_vec("add_ovf",    4'h6, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01100, 1);
    add_vec("sub_eq",     4'h5, 32'h00000005, 32'h00000005, 32'h00000000, 5'b10010, 1);
    add_vec("sra",        4'hB, 32'h80000000, 32'd36,       32'hF8000000, 5'b01000, 1);
    add_vec("mul",        4'hA, 32'h00010001, 32'h00010001, 32'h00020001, 5'b00000, 33);
    add_vec("or",         4'h0, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 5'b01000, 1);
    add_vec("xor",        4'h2, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 5'b00000, 1);
    add_vec("sltu",       4'h9, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5'b00000, 1);
    add_vec("add_carry",  4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10010, 1);
    add_vec("sub_borrow", 4'h5, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b01000, 1);
    add_vec("sub_ovf",    4'h5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110, 1);
    add_vec("sll",        4'h3, 32'h00000001, 32'd33,       32'h00000002, 5'b00000, 1);
    add_vec("srl",        4'h4, 32'h80000000, 32'd31,       32'h00000001, 5'b00000, 1);
    add_vec("andn",       4'hE, 32'h000000F0, 32'h00000030, 32'h000000C0, 5'b00000, 1);
    add_vec("nand",       4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b10000, 1);
    add_vec("nor",        4'h7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'b01000, 1);
    add_vec("xnor",       4'hF, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 5'b01000, 1);
    add_vec("and",        4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000, 1);
    add_vec("mul_ones",   4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'b00000, 33);
`ifdef ALU_SEQ_DIV_EN
    add_vec("divu",       4'hC, 32'd100,        32'd7,        32'd14,        5'b00000, 33);
    add_vec("remu",       4'hD, 32'd100,        32'd7,        32'd2,         5'b00000, 33);
    add_vec("divu_zero",  4'hC, 32'd5,          32'd0,        32'hFFFFFFFF,  5'b01000, 33);
    add_vec("remu_zero",  4'hD, 32'd123,        32'd0,        32'd123,       5'b00000, 33);
`else
    add_vec("divu_off",   4'hC, 32'd100,        32'd7,        32'd0,         5'b10001, 1);
    add_vec("remu_off",   4'hD, 32'd100,        32'd7,        32'd0,         5'b10001, 1);
`endif

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].fl, vecs[i].lat, 1'b1);
      if (vecs[i].lat > 1) begin
        bad = 0;
        repeat (vecs[i].lat - 1) begin
          @(negedge clk);
          if (in_ready || out_valid) bad++;
        end
        check({vecs[i].name, "_busy_window"}, bad, 0);
      end
      wait_drain();
    end

    // consumer stall: result held, new requests ignored
    out_ready = 1'b0;
    issue("stall_add", 4'h6, 32'd2, 32'd3, 32'd5, 5'b00000, 1, 1'b1);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stall_valid_seen", out_valid, 1);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'b1; csig = 4'h2; a = 32'hDEADBEEF; b = 32'h12345678;
      @(negedge clk);
      if (in_ready || !out_valid) bad++;
    end
    check("stall_ignored_input", bad, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("stall_no_extra_result", vcount, 0);

    // reset during a multiply: no result, ready right after release
    issue("mul_abort", 4'hA, 32'h00010001, 32'h00010001, 32'h0, 5'b0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("abort_rst_out", out, 0);
    check("abort_rst_flags", {z, n, v, c, err}, 0);
    check("abort_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("abort_no_result", vcount, 0);

    issue("post_abort_add", 4'h6, 32'd1, 32'd1, 32'd2, 5'b00000, 1, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8, power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-005 SHALL have port in_ready  output  1  block accepts operation; high only in IDLE.
REQ-006 SHALL have ports a, b  input  WIDTH  operands; csig  input  4  opcode.
REQ-007 SHALL have port out_valid  output  1  result and flags valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts result.
REQ-009 SHALL have port out  output  WIDTH  registered result.
REQ-010 SHALL have ports z, n, v, c, err  output  1 each  registered flags.

Function
REQ-011 SHALL accept an operation on a cycle with in_valid && in_ready, capturing a, b, csig.
REQ-012 SHALL decode csig: 0000 OR, 0001 AND, 0010 XOR, 0011 SLL, 0100 SRL, 0101 SUB, 0110 ADD, 0111 NOR, 1000 NAND, 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 SRA, 1100 DIVU, 1101 REMU, 1110 ANDN (a&~b), 1111 XNOR.
REQ-013 SHALL use only b[$clog2(WIDTH)-1:0] as shift amount.
REQ-014 SHALL implement FSM IDLE -> EXEC (single-cycle ops) or BUSY (MUL/DIVU/REMU) -> DONE -> IDLE.
REQ-015 SHALL assert out_valid exactly one cycle after acceptance for single-cycle ops.
REQ-016 SHALL compute MUL by shift-add and DIVU/REMU by restoring division, one bit per cycle, out_valid asserted WIDTH+1 cycles after acceptance.
REQ-017 SHALL hold out, flags, out_valid stable in DONE until out_ready; return to IDLE the cycle after out_valid && out_ready.
REQ-018 SHALL deassert in_ready in EXEC, BUSY, DONE; in_valid there is ignored.
REQ-019 SHALL set z = (out==0), n = out[WIDTH-1] for every op.
REQ-020 SHALL set c = unsigned carry-out for ADD, c = (a>=b unsigned) for SUB, else 0.
REQ-021 SHALL set v = signed overflow for ADD/SUB, else 0.
REQ-022 SHALL on DIVU by zero return all-ones; REMU by zero returns a; err=0.
REQ-023 SHALL keep in_ready low during the acceptance cycle's next state regardless of out_ready.

Reset
REQ-024 SHALL on rst_n low immediately force IDLE, out=0, z=n=v=c=err=0, out_valid=0, iteration counter=0.
REQ-025 SHALL abort any in-flight operation on reset with no result emitted; in_ready high in the first cycle after release.

Configuration
REQ-026 SHALL compile DIVU/REMU and divider datapath only when macro ALU_SEQ_DIV_EN is defined.
REQ-027 SHALL without ALU_SEQ_DIV_EN treat 1100/1101 as illegal: single-cycle latency, out=0, err=1, other flags per REQ-019..021.
REQ-028 SHALL with ALU_SEQ_DIV_EN set err=0 for every opcode.

Structure
REQ-029 SHALL place opcode enum, FSM state enum, and flags struct in package alu_seq_pkg.
REQ-030 SHALL implement the iterative multiply/divide datapath (shared accumulator, shift register, counter) in sub-module alu_iter.

Verification (WIDTH=32)
REQ-031 SHALL test ADD a=32'h7FFFFFFF b=1 -> out=32'h80000000, v=1, n=1, c=0, z=0, out_valid 1 cycle after accept.
REQ-032 SHALL test SUB a=5 b=5 -> out=0, z=1, c=1, v=0; SRA a=32'h80000000 b=36 -> out=32'hF8000000.
REQ-033 SHALL test MUL a=32'h10001 b=32'h10001 -> out=32'h00020001 after 33 cycles, in_ready low throughout.
REQ-034 SHALL test out_ready held low 10 cycles after result -> out/flags stable, new in_valid ignored.
REQ-035 SHALL test DIVU a=100 b=7 -> 14; REMU -> 2; DIVU b=0 -> 32'hFFFFFFFF (macro on); macro off -> out=0, err=1.
REQ-036 SHALL test rst_n pulsed low at cycle 10 of MUL -> out_valid never asserts, in_ready=1 after release.
